// File: rtl/stop_watch_ctrl.sv
// Front-panel controller for the cascaded stopwatch: button conditioning,
// run/stop/lap/reset sequencing and live/lap display selection.
module stop_watch_ctrl #(
  parameter int unsigned DB_LIMIT = 500000,
  parameter int unsigned DB_W     = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic [3:0] cnt_d2,
  input  logic [3:0] cnt_d1,
  input  logic [3:0] cnt_d0,
  output logic       go,
  output logic       clr,
  output logic [3:0] disp_d2,
  output logic [3:0] disp_d1,
  output logic [3:0] disp_d0,
  output logic       lap_active,
  output logic [1:0] state
);

  localparam int unsigned NB = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STOP = 2'b10,
    LAP  = 2'b11
  } state_t;

  logic [NB-1:0] raw;
  logic [NB-1:0] press;
  logic          ss_press;
  logic          lr_press;
  state_t        st;
  logic [3:0]    lap_d2;
  logic [3:0]    lap_d1;
  logic [3:0]    lap_d0;

  assign raw = {btn_lr, btn_ss};

  // Per-button synchroniser, debouncer and press-edge detector
  for (genvar g = 0; g < NB; g++) begin : g_btn
    logic            sync1;
    logic            sync2;
    logic            db;
    logic            db_q;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
        db    <= 1'b0;
        db_q  <= 1'b0;
        cnt   <= '0;
      end else begin
        sync1 <= raw[g];
        sync2 <= sync1;
        db_q  <= db;
        if (sync2 == db) begin
          cnt <= '0;
        end else if (cnt == DB_W'(DB_LIMIT - 1)) begin
          db  <= sync2;
          cnt <= '0;
        end else begin
          cnt <= cnt + DB_W'(1);
        end
      end
    end

    assign press[g] = db & ~db_q;
  end

  assign ss_press = press[0];
  assign lr_press = press[1];

  // Control FSM; START/STOP wins over a coincident LAP/RESET press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      go         <= 1'b0;
      clr        <= 1'b1;
      lap_active <= 1'b0;
      lap_d2     <= '0;
      lap_d1     <= '0;
      lap_d0     <= '0;
    end else begin
      clr <= 1'b0;
      case (st)
        IDLE: begin
          if (ss_press) begin
            st <= RUN;
            go <= 1'b1;
          end
        end
        RUN: begin
          if (ss_press) begin
            st <= STOP;
            go <= 1'b0;
          end else if (lr_press) begin
            st         <= LAP;
            lap_active <= 1'b1;
            lap_d2     <= cnt_d2;
            lap_d1     <= cnt_d1;
            lap_d0     <= cnt_d0;
          end
        end
        LAP: begin
          if (ss_press) begin
            st         <= STOP;
            go         <= 1'b0;
            lap_active <= 1'b0;
          end else if (lr_press) begin
            st         <= RUN;
            lap_active <= 1'b0;
          end
        end
        STOP: begin
          if (ss_press) begin
            st <= RUN;
            go <= 1'b1;
          end else if (lr_press) begin
            st  <= IDLE;
            clr <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign state = st;

  // Live digits pass straight through unless frozen on the lap snapshot
  assign disp_d2 = lap_active ? lap_d2 : cnt_d2;
  assign disp_d1 = lap_active ? lap_d1 : cnt_d1;
  assign disp_d0 = lap_active ? lap_d0 : cnt_d0;

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Scoreboard bench for stop_watch_ctrl: per-cycle expectations from a window-based
// button model and a transition-table FSM model, checked by an independent monitor.
module tb_stop_watch_ctrl;

  localparam int LIM = 4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;
  localparam logic [1:0] S_LAP  = 2'd3;

  typedef struct packed {
    logic [1:0]  st;
    logic        go;
    logic        clr;
    logic        lap;
    logic [11:0] disp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_ss;
  logic       btn_lr;
  logic [3:0] cnt_d2;
  logic [3:0] cnt_d1;
  logic [3:0] cnt_d0;
  logic       go;
  logic       clr;
  logic [3:0] disp_d2;
  logic [3:0] disp_d1;
  logic [3:0] disp_d0;
  logic       lap_active;
  logic [1:0] state;

  stop_watch_ctrl #(.DB_LIMIT(4), .DB_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_ss     (btn_ss),
    .btn_lr     (btn_lr),
    .cnt_d2     (cnt_d2),
    .cnt_d1     (cnt_d1),
    .cnt_d0     (cnt_d0),
    .go         (go),
    .clr        (clr),
    .disp_d2    (disp_d2),
    .disp_d1    (disp_d1),
    .disp_d0    (disp_d0),
    .lap_active (lap_active),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [1:0]  m_st;
  logic        m_clr;
  logic [11:0] m_lap;
  logic        m_db_ss, m_db_lr;
  logic        m_rose_ss, m_rose_lr;
  bit          h_ss[$];
  bit          h_lr[$];
  exp_t        exp_q[$];
  int          n_tot = 0;
  int          n_pass = 0;

  // True when the last LIM synchronised samples all disagree with the debounced level.
  // The newest history entry is still in the first sync stage, hence the -2 offset.
  function automatic bit settled_other(input bit h[$], input logic db);
    for (int i = 0; i < LIM; i++)
      if (h[h.size() - 2 - i] == db) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_st = S_IDLE;
    m_clr = 1'b1;
    m_lap = '0;
    m_db_ss = 1'b0;
    m_db_lr = 1'b0;
    m_rose_ss = 1'b0;
    m_rose_lr = 1'b0;
    h_ss.delete();
    h_lr.delete();
    repeat (LIM + 2) begin
      h_ss.push_back(1'b0);
      h_lr.push_back(1'b0);
    end
  endtask

  task automatic model_step();
    logic ssp, lrp, f;
    ssp = m_rose_ss;
    lrp = m_rose_lr;
    m_clr = 1'b0;
    case (m_st)
      S_IDLE: if (ssp) m_st = S_RUN;
      S_RUN: begin
        if (ssp) m_st = S_STOP;
        else if (lrp) begin
          m_st = S_LAP;
          m_lap = {cnt_d2, cnt_d1, cnt_d0};
        end
      end
      S_LAP: begin
        if (ssp) m_st = S_STOP;
        else if (lrp) m_st = S_RUN;
      end
      default: begin
        if (ssp) m_st = S_RUN;
        else if (lrp) begin
          m_st = S_IDLE;
          m_clr = 1'b1;
        end
      end
    endcase
    f = settled_other(h_ss, m_db_ss);
    m_rose_ss = f & ~m_db_ss;
    if (f) m_db_ss = ~m_db_ss;
    h_ss.push_back(btn_ss);
    if (h_ss.size() > LIM + 2) void'(h_ss.pop_front());
    f = settled_other(h_lr, m_db_lr);
    m_rose_lr = f & ~m_db_lr;
    if (f) m_db_lr = ~m_db_lr;
    h_lr.push_back(btn_lr);
    if (h_lr.size() > LIM + 2) void'(h_lr.pop_front());
  endtask

  function automatic exp_t exp_now();
    exp_t e;
    e.st   = m_st;
    e.go   = (m_st == S_RUN) || (m_st == S_LAP);
    e.clr  = m_clr;
    e.lap  = (m_st == S_LAP);
    e.disp = (m_st == S_LAP) ? m_lap : {cnt_d2, cnt_d1, cnt_d0};
    return e;
  endfunction

  // One clock cycle: advance the model on the edge, then drive new inputs and queue expectations
  task automatic cyc(input logic ss, input logic lr, input logic rst);
    @(posedge clk);
    if (rst_n) model_step();
    #2;
    btn_ss = ss;
    btn_lr = lr;
    cnt_d2 = 4'($urandom_range(0, 9));
    cnt_d1 = 4'($urandom_range(0, 9));
    cnt_d0 = 4'($urandom_range(0, 9));
    rst_n  = rst;
    if (!rst) model_reset();
    exp_q.push_back(exp_now());
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic press(input logic s, input logic l);
    repeat (9) cyc(s, l, 1'b1);
    idle(9);
  endtask

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, req);
  endtask

  // Monitor: compares the DUT against the oldest queued expectation each cycle
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("state", 12'(state), 12'(e.st));
      chk("go", 12'(go), 12'(e.go));
      chk("clr", 12'(clr), 12'(e.clr));
      chk("lap_active", 12'(lap_active), 12'(e.lap));
      chk("disp", {disp_d2, disp_d1, disp_d0}, e.disp);
    end
  end

  initial begin
    rst_n = 1'b0;
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    cnt_d2 = '0;
    cnt_d1 = '0;
    cnt_d0 = '0;
    model_reset();
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    idle(4);
    // Bouncing START/STOP followed by a solid hold
    for (int i = 0; i < 12; i++) cyc(((i / 2) % 2) == 0, 1'b0, 1'b1);
    repeat (10) cyc(1'b1, 1'b0, 1'b1);
    idle(10);
    // Lap freeze and release
    press(1'b0, 1'b1);
    idle(5);
    press(1'b0, 1'b1);
    // Stop, clear to idle, restart
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    idle(3);
    press(1'b1, 1'b0);
    // Coincident presses while running
    press(1'b1, 1'b1);
    // Back to idle, ignored lap in idle, then reset while in lap
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    idle(3);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    repeat (10) cyc(1'b1, 1'b0, 1'b1);
    idle(10);
    // Randomised bursts with bounce, coincident presses and occasional resets
    repeat (80) begin
      int kind;
      int len;
      kind = int'($urandom_range(0, 11));
      len  = int'($urandom_range(1, 10));
      if (kind == 0) begin
        repeat (len % 3 + 1) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end else begin
        for (int i = 0; i < len; i++)
          cyc((kind <= 4 || kind >= 9) && ($urandom_range(0, 3) != 0),
              (kind >= 5) && ($urandom_range(0, 3) != 0), 1'b1);
      end
      idle(int'($urandom_range(6, 10)));
    end
    @(negedge clk);
    #1;
    chk("drain", 12'(exp_q.size()), 12'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
